mem_portb_arbiter: RTL and testbench
====================================

Name: mem_portb_arbiter

Overview:
- Shares the data port (port B) of the dual-port unified memory between two requesters: M0 = core load/store/AMO path, M1 = DMA / framebuffer fetch engine.
- Issues one memory access per cycle and routes the 1-cycle read-first read data back to the requester that issued the read.
- Fixed priority to M0, with starvation protection for M1.
- Supports a lock for atomic read-modify-write sequences.
- Sits between the requesters and the memory port B pins.

Parameters:
- ADDR_W, 16, word address width presented to memory (bank bit + 15-bit index)
- DATA_W, 32, data width
- NB_COL, 4, byte-enable width (DATA_W/8)
- MAX_WAIT, 8, consecutive cycles M1 may be denied before it is forced a grant (range 1..255)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- m0_req_i  in  1  M0 access request, held until granted
- m0_we_i  in  NB_COL  M0 byte write enables; 0 = read
- m0_addr_i  in  ADDR_W  M0 word address
- m0_wdata_i  in  DATA_W  M0 write data
- m0_lock_i  in  1  M0 lock; keeps port ownership after a grant
- m0_gnt_o  out  1  M0 granted this cycle (combinational)
- m0_rvalid_o  out  1  M0 read data valid
- m0_rdata_o  out  DATA_W  M0 read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as M0 (M1 has no lock input)
- mem_addr_o  out  ADDR_W  memory port B address
- mem_we_o  out  NB_COL  memory port B byte write enables
- mem_din_o  out  DATA_W  memory port B write data
- mem_dout_i  in  DATA_W  memory port B read data (valid 1 cycle after address)

Behaviour:
- Reset values: all outputs 0. State = ARB_OPEN, wait_cnt = 0, rd_owner = OWN_NONE.
- Grant rule (combinational, same cycle as request):
  - In ARB_LOCKED, only M0 may be granted; M1 is denied.
  - Otherwise, if wait_cnt == MAX_WAIT and m1_req_i, grant M1.
  - Otherwise grant M0 if m0_req_i, else grant M1 if m1_req_i.
  - Never both grants in one cycle.
- Memory drive:
  - On a grant, mem_addr_o / mem_we_o / mem_din_o = granted requester's inputs.
  - With no grant, mem_we_o = 0; mem_addr_o and mem_din_o hold their previous values (registered mux select holds).
- Read return:
  - rd_owner register = owner of a granted read (we == 0), else OWN_NONE.
  - Next cycle: <owner>_rvalid_o = 1 and <owner>_rdata_o = mem_dout_i.
  - The non-owner's rdata output holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline with one result per cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle m1_req_i = 1 without m1_gnt_o.
  - Clears to 0 on an M1 grant or when m1_req_i = 0.
  - Frozen while ARB_LOCKED.
- FSM:
  - ARB_OPEN -> ARB_LOCKED when m0_gnt_o && m0_lock_i.
  - ARB_LOCKED -> ARB_OPEN when m0_lock_i == 0, evaluated the same cycle: the grant rule for that cycle already uses OPEN.
- Simultaneous events:
  - Lock request while the M1 starvation grant is due: M1 wins that cycle and the lock waits.
  - Write and read from different masters never overlap, since only one grant is issued.
- Read-during-write: read-first semantics belong to the memory; the arbiter adds no forwarding.
- Reset mid-operation clears any pending rvalid. No response is delivered after reset deassertion.

Decomposition:
- Package rv32_mem_pkg:
  - owner_e {OWN_NONE, OWN_M0, OWN_M1}
  - arb_state_e {ARB_OPEN, ARB_LOCKED}
  - struct mem_req_t {we, addr, wdata}
  - MEM_ADDR_W = 16
- Sub-module mem_arb_wait_cnt: saturating counter with inc/clr/freeze inputs and a sat_o flag.

Test Plan:
- Only M1 reads addr 0x0010 (mem holds 0xDEADBEEF) -> m1_gnt_o same cycle; m1_rvalid_o = 1 next cycle with m1_rdata_o = 0xDEADBEEF; m0_rvalid_o = 0.
- M0 and M1 request continuously, MAX_WAIT = 8 -> M0 granted 8 cycles, M1 granted on cycle 9, wait_cnt resets, then the pattern repeats every 9 cycles.
- M0 write we = 4'b0011, data 0x12345678 to 0x0020 while M1 reads 0x0020 -> M0 granted first with mem_we_o = 0011; next cycle M1 granted; M1 reads back 0x----5678 merged bytes.
- M0 lock held 12 cycles with M1 requesting -> M1 never granted during the lock; wait_cnt frozen; M1 granted on the first cycle after the lock drops if wait_cnt == MAX_WAIT.
- Back-to-back reads M0, M1, M0 at 0x1, 0x2, 0x3 -> rvalid pulses on M0, M1, M0 in consecutive cycles, each with the correct data.
- Assert rst_n_i low the cycle after an M0 read grant -> m0_rvalid_o stays 0 and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the unified-memory port B arbiter.
// Contents: owner_e (read-return owner), arb_state_e (lock FSM states),
// mem_req_t (one memory port request) and the default port widths.
package rv32_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_NB_COL = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [MEM_NB_COL-1:0] we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Saturating starvation counter for the port B arbiter.
// Ports: clk_i/rst_n_i clock and async active-low reset; inc_i count one
// denied cycle; clr_i clear (wins over inc_i); freeze_i hold the count
// (wins over both); sat_o count has reached MAX.
module mem_arb_wait_cnt #(
  parameter int unsigned MAX = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic clr_i,
  input  logic freeze_i,
  output logic sat_o
);

  localparam int unsigned CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  // Count denied cycles, saturating at MAX
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!freeze_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sat_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_portb_arbiter.sv
// Port B arbiter for the dual-port unified memory.
// Shares one access per cycle between M0 (core LSU/AMO, fixed priority,
// lockable) and M1 (DMA/framebuffer, starvation-protected), and steers the
// one-cycle-latency read data back to whichever master issued the read.
// Ports: clk_i/rst_n_i clock and async active-low reset;
//   m0_* / m1_*  request side: req/we/addr/wdata in, gnt (same cycle),
//                rvalid/rdata (cycle after a granted read); m0_lock_i holds
//                port ownership for M0 after a grant;
//   mem_*        memory port B pins (addr/we/din out, dout in).
// ADDR_W/DATA_W/NB_COL are expected to match the rv32_mem_pkg widths.
module mem_portb_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned DATA_W   = MEM_DATA_W,
  parameter int unsigned NB_COL   = MEM_NB_COL,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              m0_req_i,
  input  logic [NB_COL-1:0] m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_lock_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic [NB_COL-1:0] m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [NB_COL-1:0] mem_we_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  arb_state_e        state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  mem_req_t          m0_req_s, m1_req_s, sel_req, hold_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              locked_eff;
  logic              wait_sat;
  logic              starve;

  // Lock only holds while M0 keeps asserting it; dropping it reopens the
  // port in the same cycle.
  assign locked_eff = (state_q == ARB_LOCKED) && m0_lock_i;
  assign starve     = wait_sat && m1_req_i;

  // Grant decision; held off entirely during reset so outputs read 0
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_n_i) begin
      if (locked_eff) begin
        m0_gnt_o = m0_req_i;
      end else if (starve) begin
        m1_gnt_o = 1'b1;
      end else if (m0_req_i) begin
        m0_gnt_o = 1'b1;
      end else if (m1_req_i) begin
        m1_gnt_o = 1'b1;
      end
    end
  end

  // Lock FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_OPEN:   if (m0_gnt_o && m0_lock_i) state_d = ARB_LOCKED;
      ARB_LOCKED: if (!m0_lock_i) state_d = ARB_OPEN;
      default:    state_d = ARB_OPEN;
    endcase
  end

  // Request mux; without a grant the last address/data stay on the pins
  always_comb begin
    m0_req_s.we    = MEM_NB_COL'(m0_we_i);
    m0_req_s.addr  = MEM_ADDR_W'(m0_addr_i);
    m0_req_s.wdata = MEM_DATA_W'(m0_wdata_i);
    m1_req_s.we    = MEM_NB_COL'(m1_we_i);
    m1_req_s.addr  = MEM_ADDR_W'(m1_addr_i);
    m1_req_s.wdata = MEM_DATA_W'(m1_wdata_i);
    sel_req        = hold_q;
    sel_req.we     = '0;
    if (m0_gnt_o) begin
      sel_req = m0_req_s;
    end else if (m1_gnt_o) begin
      sel_req = m1_req_s;
    end
  end

  assign mem_addr_o = ADDR_W'(sel_req.addr);
  assign mem_we_o   = NB_COL'(sel_req.we);
  assign mem_din_o  = DATA_W'(sel_req.wdata);

  // Remember who owns the read data arriving next cycle
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (m0_gnt_o && (m0_we_i == '0)) begin
      rd_owner_d = OWN_M0;
    end else if (m1_gnt_o && (m1_we_i == '0)) begin
      rd_owner_d = OWN_M1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ARB_OPEN;
      rd_owner_q <= OWN_NONE;
      hold_q     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      if (m0_gnt_o || m1_gnt_o) hold_q <= sel_req;
      m0_rdata_q <= m0_rdata_o;
      m1_rdata_q <= m1_rdata_o;
    end
  end

  // Memory data passes straight through to the owner; the other side holds
  assign m0_rvalid_o = (rd_owner_q == OWN_M0);
  assign m1_rvalid_o = (rd_owner_q == OWN_M1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_dout_i : m0_rdata_q;
  assign m1_rdata_o  = m1_rvalid_o ? mem_dout_i : m1_rdata_q;

  mem_arb_wait_cnt #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .inc_i    (m1_req_i && !m1_gnt_o),
    .clr_i    (!m1_req_i || m1_gnt_o),
    .freeze_i (locked_eff),
    .sat_o    (wait_sat)
  );

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: a word memory with read-first behaviour sits
// on port B; a behavioural model of the arbitration rules is checked every
// falling edge, and directed scenarios add hand-computed literal checks.
module tb_mem_portb_arbiter;
  import rv32_mem_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned MW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          m0_req_i, m0_lock_i, m1_req_i;
  logic [NC-1:0] m0_we_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [NC-1:0] mem_we_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] mem_dout_i = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mem_portb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .NB_COL(NC), .MAX_WAIT(MW)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i)
  );

  // Read-first word memory with byte enables
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk_i) begin
    mem_dout_i <= mem[mem_addr_o];
    for (int b = 0; b < NC; b++)
      if (mem_we_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_din_o[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            streak;
  bit            locked;
  bit            pend_v;
  int            pend_own;
  logic [DW-1:0] pend_d, last_rd0, last_rd1, last_din;
  logic [AW-1:0] last_addr;
  bit            e_lock, e_g0, e_g1, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [NC-1:0] e_we;
  logic [DW-1:0] e_din, e_rd0, e_rd1;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      chk("rst_m0_gnt", 64'(m0_gnt_o), 64'd0);
      chk("rst_m1_gnt", 64'(m1_gnt_o), 64'd0);
      chk("rst_m0_rvalid", 64'(m0_rvalid_o), 64'd0);
      chk("rst_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
      chk("rst_m0_rdata", 64'(m0_rdata_o), 64'd0);
      chk("rst_m1_rdata", 64'(m1_rdata_o), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      chk("rst_mem_we", 64'(mem_we_o), 64'd0);
      chk("rst_mem_din", 64'(mem_din_o), 64'd0);
      streak = 0; locked = 0; pend_v = 0; pend_own = 0; pend_d = '0;
      last_rd0 = '0; last_rd1 = '0; last_din = '0; last_addr = '0;
    end else begin
      e_lock = locked && m0_lock_i;
      e_g0 = 0; e_g1 = 0;
      if (e_lock) e_g0 = m0_req_i;
      else if (streak == int'(MW) && m1_req_i) e_g1 = 1;
      else if (m0_req_i) e_g0 = 1;
      else if (m1_req_i) e_g1 = 1;
      e_addr = e_g0 ? m0_addr_i  : e_g1 ? m1_addr_i  : last_addr;
      e_din  = e_g0 ? m0_wdata_i : e_g1 ? m1_wdata_i : last_din;
      e_we   = e_g0 ? m0_we_i    : e_g1 ? m1_we_i    : '0;
      e_rv0  = pend_v && pend_own == 0;
      e_rv1  = pend_v && pend_own == 1;
      e_rd0  = e_rv0 ? pend_d : last_rd0;
      e_rd1  = e_rv1 ? pend_d : last_rd1;
      chk("m0_gnt", 64'(m0_gnt_o), 64'(e_g0));
      chk("m1_gnt", 64'(m1_gnt_o), 64'(e_g1));
      chk("mem_addr", 64'(mem_addr_o), 64'(e_addr));
      chk("mem_we", 64'(mem_we_o), 64'(e_we));
      chk("mem_din", 64'(mem_din_o), 64'(e_din));
      chk("m0_rvalid", 64'(m0_rvalid_o), 64'(e_rv0));
      chk("m1_rvalid", 64'(m1_rvalid_o), 64'(e_rv1));
      chk("m0_rdata", 64'(m0_rdata_o), 64'(e_rd0));
      chk("m1_rdata", 64'(m1_rdata_o), 64'(e_rd1));
      last_rd0 = e_rd0; last_rd1 = e_rd1;
      last_addr = e_addr; last_din = e_din;
      pend_v   = (e_g0 && m0_we_i == '0) || (e_g1 && m1_we_i == '0);
      pend_own = e_g0 ? 0 : 1;
      pend_d   = mem[e_addr];
      if (!e_lock) begin
        if (!m1_req_i || e_g1) streak = 0;
        else if (streak < int'(MW)) streak++;
      end
      locked = e_lock || (e_g0 && m0_lock_i);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle(); @(posedge clk_i); #1; endtask
  task automatic mid();        @(negedge clk_i); #1; endtask

  int n0, n1, first_m1, second_m1, m1_locked_gnts;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0020] = 32'hAABBCCDD;
    mem[16'h0001] = 32'h11111111;
    mem[16'h0002] = 32'h22222222;
    mem[16'h0003] = 32'h33333333;
    rst_n_i = 0; m0_lock_i = 0;
    m0_req_i = 0; m0_we_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = '0; m1_addr_i = '0; m1_wdata_i = '0;

    // Request during reset must not be granted
    next_cycle();
    m0_req_i = 1; m0_addr_i = 16'h0055;
    mid();
    chk("rst_req_no_gnt", 64'(m0_gnt_o), 64'd0);
    next_cycle();
    m0_req_i = 0; m0_addr_i = '0;
    rst_n_i = 1;
    next_cycle();

    // M1 alone reads 0x0010
    m1_req_i = 1; m1_addr_i = 16'h0010;
    mid();
    chk("t1_m1_gnt", 64'(m1_gnt_o), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h0010);
    next_cycle();
    m1_req_i = 0;
    mid();
    chk("t1_m1_rvalid", 64'(m1_rvalid_o), 64'd1);
    chk("t1_m1_rdata", 64'(m1_rdata_o), 64'hDEADBEEF);
    chk("t1_m0_rvalid", 64'(m0_rvalid_o), 64'd0);
    next_cycle();

    // Both request continuously: M1 forced in every 9th cycle
    m0_req_i = 1; m0_addr_i = 16'h0100;
    m1_req_i = 1; m1_addr_i = 16'h0200;
    n0 = 0; n1 = 0; first_m1 = 0; second_m1 = 0;
    for (int c = 1; c <= 18; c++) begin
      mid();
      if (m0_gnt_o) n0++;
      if (m1_gnt_o) begin
        n1++;
        if (first_m1 == 0) first_m1 = c; else second_m1 = c;
      end
      next_cycle();
    end
    chk("t2_m0_grants", 64'(n0), 64'd16);
    chk("t2_m1_grants", 64'(n1), 64'd2);
    chk("t2_first_m1", 64'(first_m1), 64'd9);
    chk("t2_second_m1", 64'(second_m1), 64'd18);
    m0_req_i = 0; m1_req_i = 0;
    next_cycle();

    // M0 partial write vs M1 read of the same word
    m0_req_i = 1; m0_we_i = 4'b0011; m0_addr_i = 16'h0020; m0_wdata_i = 32'h12345678;
    m1_req_i = 1; m1_addr_i = 16'h0020;
    mid();
    chk("t3_m0_gnt", 64'(m0_gnt_o), 64'd1);
    chk("t3_m1_denied", 64'(m1_gnt_o), 64'd0);
    chk("t3_mem_we", 64'(mem_we_o), 64'b0011);
    next_cycle();
    m0_req_i = 0; m0_we_i = '0;
    mid();
    chk("t3_m1_gnt", 64'(m1_gnt_o), 64'd1);
    next_cycle();
    m1_req_i = 0;
    mid();
    chk("t3_m1_rvalid", 64'(m1_rvalid_o), 64'd1);
    chk("t3_merged", 64'(m1_rdata_o), 64'hAABB5678);
    next_cycle();

    // Back-to-back reads M0, M1, M0
    m0_req_i = 1; m0_addr_i = 16'h0001;
    mid();
    chk("t5_a_gnt", 64'(m0_gnt_o), 64'd1);
    next_cycle();
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 16'h0002;
    mid();
    chk("t5_a_rvalid", 64'(m0_rvalid_o), 64'd1);
    chk("t5_a_rdata", 64'(m0_rdata_o), 64'h11111111);
    next_cycle();
    m1_req_i = 0; m0_req_i = 1; m0_addr_i = 16'h0003;
    mid();
    chk("t5_b_rvalid", 64'(m1_rvalid_o), 64'd1);
    chk("t5_b_rdata", 64'(m1_rdata_o), 64'h22222222);
    chk("t5_b_m0_hold", 64'(m0_rdata_o), 64'h11111111);
    next_cycle();
    m0_req_i = 0;
    mid();
    chk("t5_c_rvalid", 64'(m0_rvalid_o), 64'd1);
    chk("t5_c_rdata", 64'(m0_rdata_o), 64'h33333333);
    chk("t5_c_m1_idle", 64'(m1_rvalid_o), 64'd0);
    next_cycle();

    // Lock: 7 starving cycles, lock grant, 12 locked cycles, release
    m0_req_i = 1; m0_addr_i = 16'h0301;
    m1_req_i = 1; m1_addr_i = 16'h0300;
    repeat (7) begin mid(); next_cycle(); end
    m0_lock_i = 1;
    mid();
    chk("t4_lock_gnt", 64'(m0_gnt_o), 64'd1);
    next_cycle();
    m1_locked_gnts = 0;
    repeat (12) begin
      mid();
      if (m1_gnt_o) m1_locked_gnts++;
      next_cycle();
    end
    chk("t4_m1_locked_out", 64'(m1_locked_gnts), 64'd0);
    m0_lock_i = 0;
    mid();
    chk("t4_release_m1", 64'(m1_gnt_o), 64'd1);
    chk("t4_release_m0", 64'(m0_gnt_o), 64'd0);
    next_cycle();

    // Lock request while the starvation grant is due
    repeat (8) begin mid(); next_cycle(); end
    m0_lock_i = 1;
    mid();
    chk("t6_starve_wins", 64'(m1_gnt_o), 64'd1);
    next_cycle();
    mid();
    chk("t6_lock_taken", 64'(m0_gnt_o), 64'd1);
    next_cycle();
    mid();
    chk("t6_m1_locked_out", 64'(m1_gnt_o), 64'd0);
    next_cycle();
    m0_lock_i = 0; m0_req_i = 0; m1_req_i = 0;
    next_cycle();

    // Reset the cycle after an M0 read grant
    m0_req_i = 1; m0_addr_i = 16'h0010;
    mid();
    chk("t7_gnt", 64'(m0_gnt_o), 64'd1);
    next_cycle();
    m0_req_i = 0;
    rst_n_i = 0;
    #1;
    chk("t7_async_rvalid", 64'(m0_rvalid_o), 64'd0);
    chk("t7_async_rdata", 64'(m0_rdata_o), 64'd0);
    chk("t7_async_m1_rdata", 64'(m1_rdata_o), 64'd0);
    chk("t7_async_addr", 64'(mem_addr_o), 64'd0);
    next_cycle();
    next_cycle();
    rst_n_i = 1;
    mid();
    chk("t7_no_late_rvalid", 64'(m0_rvalid_o), 64'd0);
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
